// File: rtl/apb_master_fsm.sv
// apb_master_fsm: single-transfer APB4 requester for the AXI-APB bridge.
// Decodes the request address onto NUM_SLAVES 4 KiB windows starting at
// 0x1000, runs SETUP/ACCESS, and returns data plus an error code.
// Optional macro APB_MASTER_TIMEOUT_EN bounds the ACCESS phase to
// TIMEOUT_CYCLES not-ready cycles, then ends the transfer with SLVERR.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | PSEL high, PENABLE low
// ACCESS | PSEL and PENABLE high, waiting for the selected PREADY
// RESP   | rsp_valid high, response held until rsp_ready
module apb_master_fsm #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESET,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   input  logic [DATA_WIDTH/8-1:0]          req_strb,
   input  logic [2:0]                       req_prot,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [1:0]                       rsp_err,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic                             PWRITE,
   output logic [2:0]                       PPROT,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [DATA_WIDTH/8-1:0]          PSTRB,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR
);

   localparam int STRBW = DATA_WIDTH/8;
   localparam int IDXW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int PAGEW = ADDR_WIDTH - 12;
   localparam logic [PAGEW-1:0] LAST_PAGE = PAGEW'(NUM_SLAVES);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                  state_q;
   logic [IDXW-1:0]         sel_idx_q;
   logic [NUM_SLAVES-1:0]   psel_q;
   logic                    penable_q;
   logic                    pwrite_q;
   logic [2:0]              pprot_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [STRBW-1:0]        pstrb_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]              rsp_err_q;

   logic [PAGEW-1:0]        page;
   logic                    hit;
   logic [IDXW-1:0]         dec_idx;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_WIDTH-1:0]   sel_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
   logic [CNTW-1:0]         to_cnt_q;
`else
   logic                    unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // Address decode: 4 KiB page n (1..NUM_SLAVES) selects slave n-1.
   always_comb begin
      page    = req_addr[ADDR_WIDTH-1:12];
      hit     = (page != '0) && (page <= LAST_PAGE);
      dec_idx = IDXW'(page - PAGEW'(1));
      dec_sel = '0;
      if (hit) dec_sel[dec_idx] = 1'b1;
   end

   assign sel_ready = PREADY[sel_idx_q];
   assign sel_err   = PSLVERR[sel_idx_q];
   assign sel_rdata = PRDATA[sel_idx_q*DATA_WIDTH +: DATA_WIDTH];

   assign req_ready = (state_q == IDLE) && !PRESET;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PPROT     = pprot_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PSTRB     = pstrb_q;

   // Transfer sequencing with all APB and response outputs registered.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         sel_idx_q   <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pprot_q     <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 2'b00;
`ifdef APB_MASTER_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (hit) begin
                     state_q   <= SETUP;
                     sel_idx_q <= dec_idx;
                     psel_q    <= dec_sel;
                     penable_q <= 1'b0;
                     pwrite_q  <= req_write;
                     pprot_q   <= req_prot;
                     paddr_q   <= req_addr;
                     pwdata_q  <= req_write ? req_wdata : '0;
                     pstrb_q   <= req_write ? req_strb : '0;
                  end else begin
                     // Unmapped address: answer DECERR without touching the bus.
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= 2'b11;
                  end
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
               to_cnt_q  <= '0;
`endif
            end
            ACCESS: begin
               if (sel_ready) begin
                  state_q     <= RESP;
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= pwrite_q ? '0 : sel_rdata;
                  rsp_err_q   <= sel_err ? 2'b10 : 2'b00;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (to_cnt_q == CNT_LAST) begin
                  state_q     <= RESP;
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 2'b10;
               end else begin
                  to_cnt_q <= to_cnt_q + CNTW'(1);
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: inputs change and outputs are sampled
// 1 time unit after each rising PCLK edge.
module tb_apb_master_fsm;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_strb;
   logic [2:0]    req_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_err;
   logic [3:0]    PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [2:0]    PPROT;
   logic [31:0]   PADDR;
   logic [31:0]   PWDATA;
   logic [3:0]    PSTRB;
   logic [127:0]  PRDATA;
   logic [3:0]    PREADY;
   logic [3:0]    PSLVERR;

   int n_assert = 0;
   int n_fail   = 0;

   apb_master_fsm dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .req_prot  (req_prot),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PPROT     (PPROT),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PSTRB     (PSTRB),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      PRESET    = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_prot  = '0;
      rsp_ready = 1'b0;
      PRDATA    = {32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
      PREADY    = 4'b1111;
      PSLVERR   = 4'b0000;

      // Reset state
      tick();
      tick();
      chk("rst_psel", PSEL, 4'b0000);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_rsp_err", rsp_err, 2'b00);
      PRESET = 1'b0;
      tick();
      chk("idle_req_ready", req_ready, 1'b1);

      // Write 0xDEADBEEF to 0x3010, slave 2 ready at once
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_3010;
      req_wdata = 32'hDEAD_BEEF; req_strb = 4'b1111; req_prot = 3'b010;
      tick();
      req_valid = 1'b0;
      chk("wr_setup_psel", PSEL, 4'b0100);
      chk("wr_setup_penable", PENABLE, 1'b0);
      chk("wr_setup_paddr", PADDR, 32'h0000_3010);
      chk("wr_setup_pwrite", PWRITE, 1'b1);
      chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
      chk("wr_setup_pstrb", PSTRB, 4'b1111);
      chk("wr_setup_pprot", PPROT, 3'b010);
      chk("wr_setup_req_ready", req_ready, 1'b0);
      tick();
      chk("wr_access_psel", PSEL, 4'b0100);
      chk("wr_access_penable", PENABLE, 1'b1);
      chk("wr_access_rsp_valid", rsp_valid, 1'b0);
      tick();
      chk("wr_resp_valid", rsp_valid, 1'b1);
      chk("wr_resp_psel", PSEL, 4'b0000);
      chk("wr_resp_penable", PENABLE, 1'b0);
      chk("wr_resp_err", rsp_err, 2'b00);
      chk("wr_resp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("wr_done_valid", rsp_valid, 1'b0);
      chk("wr_done_req_ready", req_ready, 1'b1);

      // Read back 0x3010; strobes and write data forced to zero
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3010;
      req_wdata = 32'h1234_5678; req_strb = 4'b1111; req_prot = 3'b000;
      tick();
      req_valid = 1'b0;
      chk("rd_setup_psel", PSEL, 4'b0100);
      chk("rd_setup_pstrb", PSTRB, 4'b0000);
      chk("rd_setup_pwdata", PWDATA, 32'h0);
      chk("rd_setup_pwrite", PWRITE, 1'b0);
      tick();
      chk("rd_access_penable", PENABLE, 1'b1);
      tick();
      chk("rd_resp_valid", rsp_valid, 1'b1);
      chk("rd_resp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("rd_resp_err", rsp_err, 2'b00);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rd_done_valid", rsp_valid, 1'b0);

      // Read 0x1004 with three wait states; other slaves' error lines ignored
      PREADY  = 4'b1110;
      PSLVERR = 4'b1110;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1004;
      tick();
      req_valid = 1'b0;
      chk("ws_setup_psel", PSEL, 4'b0001);
      chk("ws_setup_penable", PENABLE, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ws_access_penable", PENABLE, 1'b1);
         chk("ws_access_psel", PSEL, 4'b0001);
         chk("ws_access_paddr", PADDR, 32'h0000_1004);
         chk("ws_access_pwrite", PWRITE, 1'b0);
         chk("ws_access_rsp_valid", rsp_valid, 1'b0);
         if (i == 3) PREADY = 4'b1111;
      end
      tick();
      chk("ws_resp_valid", rsp_valid, 1'b1);
      chk("ws_resp_rdata", rsp_rdata, 32'h1111_1111);
      chk("ws_resp_err", rsp_err, 2'b00);
      PSLVERR = 4'b0000;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Unmapped address 0x8000 -> DECERR one cycle after acceptance
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_8000;
      tick();
      req_valid = 1'b0;
      chk("dec_resp_valid", rsp_valid, 1'b1);
      chk("dec_psel", PSEL, 4'b0000);
      chk("dec_err", rsp_err, 2'b11);
      chk("dec_rdata", rsp_rdata, 32'h0);
      chk("dec_req_ready", req_ready, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Top of slave 3's window
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4FFC;
      tick();
      req_valid = 1'b0;
      chk("top_setup_psel", PSEL, 4'b1000);
      tick();
      tick();
      chk("top_resp_rdata", rsp_rdata, 32'h3333_3333);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Write to 0x2000 with PSLVERR, response held under backpressure
      PSLVERR = 4'b0010;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_2000;
      req_wdata = 32'hA5A5_5A5A; req_strb = 4'b0011;
      tick();
      req_valid = 1'b0;
      chk("err_setup_psel", PSEL, 4'b0010);
      chk("err_setup_pstrb", PSTRB, 4'b0011);
      tick();
      tick();
      chk("err_resp_valid", rsp_valid, 1'b1);
      chk("err_resp_err", rsp_err, 2'b10);
      PSLVERR = 4'b0000;
      PREADY  = 4'b1011;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3010;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_err", rsp_err, 2'b10);
         chk("hold_rdata", rsp_rdata, 32'h0);
         chk("hold_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("b2b_valid_low", rsp_valid, 1'b0);
      chk("b2b_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk("b2b_setup_psel", PSEL, 4'b0100);
      tick();
      chk("b2b_access_penable", PENABLE, 1'b1);

      // Reset during ACCESS
      PRESET = 1'b1;
      tick();
      chk("mid_rst_psel", PSEL, 4'b0000);
      chk("mid_rst_penable", PENABLE, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_paddr", PADDR, 32'h0);
      chk("mid_rst_req_ready", req_ready, 1'b0);
      PRESET = 1'b0;
      PREADY = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_rsp_valid", rsp_valid, 1'b0);
         chk("post_rst_psel", PSEL, 4'b0000);
         chk("post_rst_req_ready", req_ready, 1'b1);
      end

      // Slave 0 never ready: timeout build aborts, default build keeps waiting
      PREADY = 4'b1110;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      chk("to_access16_penable", PENABLE, 1'b1);
      chk("to_access16_rsp_valid", rsp_valid, 1'b0);
      tick();
`ifdef APB_MASTER_TIMEOUT_EN
      chk("to_abort_valid", rsp_valid, 1'b1);
      chk("to_abort_err", rsp_err, 2'b10);
      chk("to_abort_rdata", rsp_rdata, 32'h0);
      chk("to_abort_psel", PSEL, 4'b0000);
      chk("to_abort_penable", PENABLE, 1'b0);
`else
      chk("nto_still_penable", PENABLE, 1'b1);
      chk("nto_still_psel", PSEL, 4'b0001);
      chk("nto_no_rsp", rsp_valid, 1'b0);
      PREADY = 4'b1111;
      tick();
      chk("nto_resp_valid", rsp_valid, 1'b1);
      chk("nto_resp_rdata", rsp_rdata, 32'h1111_1111);
      chk("nto_resp_err", rsp_err, 2'b00);
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("final_req_ready", req_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_fsm.md
# apb_master_fsm

Upstream APB requester for the AXI-APB bridge. It accepts one decoded transfer at a time from the bridge's AXI-side command interface. It selects one of `NUM_SLAVES` APB slaves by address, including the 32-bit memory slave at 0x0000_3000–0x0000_3FFF, and drives the APB4 SETUP/ACCESS protocol. It returns read data and an error code on a response channel.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; `PSTRB` width is `DATA_WIDTH/8`.
- `NUM_SLAVES`, 4, number of APB slaves. Slave `i` owns the range `0x1000*(i+1)` to `0x1000*(i+1)+0xFFF`.
- `TIMEOUT_CYCLES`, 16, maximum number of ACCESS cycles. Used only with `APB_MASTER_TIMEOUT_EN`.
- `PCLK` in 1: APB clock; all logic is on the rising edge.
- `PRESET` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted.
- `req_write` in 1: 1 = write.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: write data.
- `req_strb` in DATA_WIDTH/8: write strobes.
- `req_prot` in 3: protection attributes.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_rdata` out DATA_WIDTH: read data.
- `rsp_err` out 2: response code. 00 OKAY, 10 SLVERR, 11 DECERR.
- `PSEL` out NUM_SLAVES: one-hot slave select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB write.
- `PPROT` out 3: APB protection.
- `PADDR` out ADDR_WIDTH: APB address.
- `PWDATA` out DATA_WIDTH: APB write data.
- `PSTRB` out DATA_WIDTH/8: APB strobes.
- `PRDATA` in NUM_SLAVES*DATA_WIDTH: slave `i` occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `PREADY` in NUM_SLAVES: per-slave ready.
- `PSLVERR` in NUM_SLAVES: per-slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready`=1; in every other state it is 0.
  - On `req_valid`, register the request and decode `req_addr`.
  - Address hit on slave `i`: go to SETUP.
  - Address miss: go to RESP with `rsp_err`=11 and `rsp_rdata`=0. No APB transfer is issued.
- SETUP:
  - `PSEL[i]`=1, `PENABLE`=0.
  - `PADDR` carries the full unmodified address; the slave subtracts its own base.
  - Go to ACCESS unconditionally.
- ACCESS:
  - `PSEL[i]`=1, `PENABLE`=1.
  - Stay while `PREADY[i]`=0.
  - When `PREADY[i]`=1, capture read data into `rsp_rdata` (reads only; writes return 0).
  - Set `rsp_err`=10 if `PSLVERR[i]`, else 00. Go to RESP.
- RESP:
  - `rsp_valid`=1; `PSEL`=0, `PENABLE`=0.
  - Hold `rsp_rdata` and `rsp_err` stable until `rsp_ready`, then go to IDLE.
- Reads drive `PSTRB`=0 and `PWDATA`=0 regardless of `req_strb`. Writes drive the registered `req_strb`.
- `PADDR`, `PWRITE`, `PPROT`, `PWDATA` and `PSTRB` are registered. They stay stable from SETUP through the last ACCESS cycle.
- Only `PREADY`/`PSLVERR`/`PRDATA` of the selected slave are observed; all other slaves' inputs are ignored.
- Reset, including mid-transfer, takes effect at the next edge:
  - state becomes IDLE;
  - `PSEL`=0, `PENABLE`=0, `rsp_valid`=0;
  - `PADDR`, `PWDATA`, `PSTRB`, `PPROT`, `PWRITE`, `rsp_rdata` all become 0; `rsp_err`=00;
  - `req_ready`=0 while `PRESET`=1.
  - A transfer interrupted by reset produces no response.

## Timing
- Minimum latency:
  - accept at edge N;
  - SETUP during cycle N+1;
  - ACCESS during N+2 with `PREADY`=1;
  - `rsp_valid` during N+3.
- Each wait state adds one cycle.
- DECERR: `rsp_valid` in the cycle after acceptance.
- Back-to-back: `req_ready` rises in the cycle after the `rsp_valid && rsp_ready` edge. There is one transfer in flight at most.
- `PSEL` never deasserts between SETUP and ACCESS.

## Configuration
- Macro `APB_MASTER_TIMEOUT_EN`.
- Defined: a counter is cleared on entry to ACCESS and increments each ACCESS cycle with `PREADY[i]`=0. When it reaches `TIMEOUT_CYCLES`, the transfer is abandoned:
  - `PSEL`/`PENABLE` drop on the next edge;
  - go to RESP with `rsp_err`=10, `rsp_rdata`=0.
- Not defined: there is no counter, and ACCESS waits indefinitely for `PREADY`.

## Test plan
- Write 0xDEADBEEF, strb 1111, to 0x0000_3010 (slave 2 ready immediately), then read 0x0000_3010 → `PSEL`=0100, read `PSTRB`=0000, `rsp_rdata`=0xDEADBEEF, `rsp_err`=00, 3-cycle latency each.
- Read 0x0000_1004 with `PREADY[0]` held low 3 cycles → ACCESS lasts 4 cycles; PADDR/PWRITE stable throughout; response on cycle 6.
- Read 0x0000_8000 → no `PSEL` asserted; `rsp_err`=11, `rsp_rdata`=0, `rsp_valid` 1 cycle after acceptance.
- Slave returns `PSLVERR`=1 with `PREADY`=1 on a write to 0x0000_2000 → `rsp_err`=10. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data held; `req_ready`=0 until the handshake.
- Assert `PRESET` during ACCESS → next edge `PSEL`=0, `PENABLE`=0, `rsp_valid`=0, state IDLE. No response is produced for the aborted transfer.
- With `APB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `PREADY` never rises → after 16 ACCESS cycles the transfer aborts with `rsp_err`=10, `rsp_rdata`=0.
